// File: rtl/line_bank_sched_pkg.sv
// Shared constants and types for the GBA line-bank ring scheduler.
package line_bank_sched_pkg;
  localparam int LINE_PXLS   = 240;
  localparam int FRAME_LINES = 160;
  localparam int ADDR_W      = 8;

  typedef logic [1:0] bank_t;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
endpackage

// File: rtl/line_bank_sched_writer.sv
// Capture-side writer: pixel address and bank counters, line completion strobe,
// and the stall that holds off writing while the next bank is still the prev tap.
module line_bank_writer #(
  parameter int LINE_PXLS   = 240,
  parameter int FRAME_LINES = 160,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_valid,
  input  logic              run,
  input  logic              frame_rst,
  input  logic              bank_clr,
  input  logic [1:0]        rd_prev,
  output logic              wr_en,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done,
  output logic [1:0]        done_bank,
  output logic [7:0]        wr_line,
  output logic              drop
);
  import line_bank_sched_pkg::*;

  logic [ADDR_W-1:0] addr_q;
  bank_t             bank_q;
  logic [7:0]        line_q;
  logic              blocked, stall, accept;

  // A blocked writer stays parked at addr 0 until the reader moves prev off its bank.
  assign stall     = blocked & run & (bank_q == rd_prev);
  assign accept    = pxl_valid & ~stall;
  assign drop      = pxl_valid & stall;
  assign done      = accept & (addr_q == ADDR_W'(LINE_PXLS - 1));
  assign done_bank = bank_q;
  assign wr_line   = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_bank <= '0;
      wr_addr <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
      line_q  <= '0;
      blocked <= 1'b0;
    end else begin
      wr_en   <= accept;
      wr_bank <= bank_q;
      wr_addr <= addr_q;
      if (blocked && !stall) blocked <= 1'b0;
      if (accept) addr_q <= done ? '0 : addr_q + ADDR_W'(1);
      if (done) begin
        bank_q <= bank_q + 2'd1;
        if (line_q != 8'(FRAME_LINES - 1)) line_q <= line_q + 8'd1;
        if (run && ((bank_q + 2'd1) == rd_prev)) blocked <= 1'b1;
      end
      // Frame restart wins over a same-cycle completion for addr/line.
      if (frame_rst) begin
        addr_q <= '0;
        line_q <= '0;
      end
      if (bank_clr) begin
        bank_q  <= '0;
        blocked <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/line_bank_sched.sv
// 4-bank GBA line ring sequencer: capture writes one bank while the HDMI path
// reads prev/cur/next taps from the other three.
module line_bank_sched #(
  parameter int LINE_PXLS   = line_bank_sched_pkg::LINE_PXLS,
  parameter int FRAME_LINES = line_bank_sched_pkg::FRAME_LINES,
  parameter int ADDR_W      = line_bank_sched_pkg::ADDR_W
) (
  input  logic              pxlClk,
  input  logic              rstN,
  input  logic              gbaPxlValid,
  input  logic              gbaNewFrame,
  input  logic              nextLine,
  output logic              wrEn,
  output logic [1:0]        wrBank,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [1:0]        rdBankPrev,
  output logic [1:0]        rdBankCur,
  output logic [1:0]        rdBankNext,
  output logic [7:0]        rdLine,
  output logic              sameLine,
  output logic              frameStart,
  output logic              overflow,
  output logic              underrun
);
  import line_bank_sched_pkg::*;

  localparam logic [7:0] LAST = 8'(FRAME_LINES - 1);

  state_t     state, state_n;
  bank_t      cur, cur_n, prv, prv_n, nxt, nxt_n;
  logic [7:0] rd_line, line_n;
  logic [1:0] ready, ready_n;
  logic       nf_d, nf, adv, resync, fire, fs_pend;
  logic       done, drop;
  logic [1:0] done_bank;
  logic [7:0] wr_line;

  assign nf     = gbaNewFrame & ~nf_d;
  assign resync = (state == RUN) & nf & (rd_line != LAST);
  assign adv    = (state == RUN) & nextLine & (ready != 2'd0) & ~resync;

  line_bank_writer #(
    .LINE_PXLS  (LINE_PXLS),
    .FRAME_LINES(FRAME_LINES),
    .ADDR_W     (ADDR_W)
  ) u_writer (
    .clk      (pxlClk),
    .rst_n    (rstN),
    .pxl_valid(gbaPxlValid & (state != IDLE)),
    .run      (state == RUN),
    .frame_rst(nf),
    .bank_clr (nf & (state == IDLE)),
    .rd_prev  (prv),
    .wr_en    (wrEn),
    .wr_bank  (wrBank),
    .wr_addr  (wrAddr),
    .done     (done),
    .done_bank(done_bank),
    .wr_line  (wr_line),
    .drop     (drop)
  );

  always_comb begin
    state_n = state;
    cur_n   = cur;
    prv_n   = prv;
    line_n  = rd_line;
    ready_n = ready;
    fire    = 1'b0;
    unique case (state)
      IDLE: if (nf) begin
        state_n = FILL;
        ready_n = '0;
      end
      FILL: begin
        if (nf) ready_n = '0;
        else if (done && wr_line == 8'd1) begin
          state_n = RUN;
          cur_n   = done_bank - 2'd1;
          prv_n   = cur_n;
          line_n  = '0;
          ready_n = 2'd1;
          fire    = 1'b1;
        end
      end
      RUN: begin
        ready_n = ready + 2'(done) - 2'(adv);
        if (resync) begin
          state_n = FILL;
          ready_n = '0;
        end else if (adv) begin
          cur_n = cur + 2'd1;
          prv_n = cur;
          if (rd_line == LAST) begin
            // Onto line 0 of the next frame: top-edge replicate.
            line_n = '0;
            prv_n  = cur_n;
            fire   = 1'b1;
          end else begin
            line_n = rd_line + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // next tap points at cur's successor only when it is complete and not past the bottom.
    nxt_n = ((ready_n != 2'd0) && (line_n != LAST)) ? cur_n + 2'd1 : cur_n;
    if (state_n != RUN) nxt_n = nxt;
  end

  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      cur        <= '0;
      prv        <= '0;
      nxt        <= '0;
      rd_line    <= '0;
      ready      <= '0;
      sameLine   <= 1'b1;
      fs_pend    <= 1'b0;
      frameStart <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      nf_d       <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      prv        <= prv_n;
      nxt        <= nxt_n;
      rd_line    <= line_n;
      ready      <= ready_n;
      sameLine   <= (state_n != RUN) | (ready_n == 2'd0);
      fs_pend    <= fire;
      frameStart <= fs_pend;
      overflow   <= overflow | drop;
      underrun   <= underrun | (nextLine & sameLine);
      nf_d       <= gbaNewFrame;
    end
  end

  assign rdBankPrev = prv;
  assign rdBankCur  = cur;
  assign rdBankNext = nxt;
  assign rdLine     = rd_line;
endmodule

// File: tb/tb_line_bank_sched.sv
// Directed bench for line_bank_sched: fill, full-frame rotation, underrun,
// writer block/overflow and mid-frame resync.
module tb_line_bank_sched;
  logic       pxlClk = 1'b0, rstN = 1'b0;
  logic       gbaPxlValid = 1'b0, gbaNewFrame = 1'b0, nextLine = 1'b0;
  logic       wrEn, sameLine, frameStart, overflow, underrun;
  logic [1:0] wrBank, rdBankPrev, rdBankCur, rdBankNext;
  logic [7:0] wrAddr, rdLine;

  int checks = 0, errors = 0;
  int wr_cnt = 0, fs_cnt = 0, fs_line = -1;
  int base;

  line_bank_sched dut (
    .pxlClk     (pxlClk),
    .rstN       (rstN),
    .gbaPxlValid(gbaPxlValid),
    .gbaNewFrame(gbaNewFrame),
    .nextLine   (nextLine),
    .wrEn       (wrEn),
    .wrBank     (wrBank),
    .wrAddr     (wrAddr),
    .rdBankPrev (rdBankPrev),
    .rdBankCur  (rdBankCur),
    .rdBankNext (rdBankNext),
    .rdLine     (rdLine),
    .sameLine   (sameLine),
    .frameStart (frameStart),
    .overflow   (overflow),
    .underrun   (underrun)
  );

  always #5 pxlClk = ~pxlClk;

  always @(negedge pxlClk) begin
    if (wrEn) wr_cnt++;
    if (frameStart) begin
      fs_cnt++;
      fs_line = int'(rdLine);
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic pixels(input int n);
    gbaPxlValid = 1'b1;
    repeat (n) tick();
    gbaPxlValid = 1'b0;
  endtask

  task automatic nl();
    nextLine = 1'b1;
    tick();
    nextLine = 1'b0;
    tick();
    tick();
  endtask

  task automatic nf_pulse();
    gbaNewFrame = 1'b1;
    tick();
    gbaNewFrame = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    repeat (3) tick();
    rstN = 1'b1;
    tick();
  endtask

  task automatic chk_taps(input string tag, input int p, input int c, input int n);
    chk({tag, "_prev"}, int'(rdBankPrev), p);
    chk({tag, "_cur"},  int'(rdBankCur),  c);
    chk({tag, "_next"}, int'(rdBankNext), n);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wren"},  int'(wrEn),   0);
    chk({tag, "_wbank"}, int'(wrBank), 0);
    chk({tag, "_waddr"}, int'(wrAddr), 0);
    chk_taps(tag, 0, 0, 0);
    chk({tag, "_line"},  int'(rdLine),     0);
    chk({tag, "_same"},  int'(sameLine),   1);
    chk({tag, "_fs"},    int'(frameStart), 0);
    chk({tag, "_ovf"},   int'(overflow),   0);
    chk({tag, "_und"},   int'(underrun),   0);
  endtask

  // Reset, fill lines 0/1 and enter RUN with cur=0, next=1.
  task automatic start_frame();
    do_reset();
    nf_pulse();
    pixels(480);
    repeat (4) tick();
  endtask

  initial begin
    // Power-on reset and pixels ignored before any frame start
    repeat (3) tick();
    chk_reset_state("por");
    rstN = 1'b1;
    tick();
    base = wr_cnt;
    pixels(10);
    chk("idle_ignore", wr_cnt - base, 0);

    // Fill: two lines, address wrap and bank advance, then RUN
    nf_pulse();
    gbaPxlValid = 1'b1;
    for (int k = 0; k < 480; k++) begin
      tick();
      if (k == 0) begin
        chk("fill_wren0", int'(wrEn), 1);
        chk("fill_addr0", int'(wrAddr), 0);
        chk("fill_bank0", int'(wrBank), 0);
      end
      if (k == 239) begin
        chk("fill_addr239", int'(wrAddr), 239);
        chk("fill_bank239", int'(wrBank), 0);
      end
      if (k == 240) begin
        chk("fill_addr240", int'(wrAddr), 0);
        chk("fill_bank240", int'(wrBank), 1);
      end
      if (k == 479) chk("fill_bank479", int'(wrBank), 1);
    end
    gbaPxlValid = 1'b0;
    repeat (4) tick();
    chk("fill_fs_cnt", fs_cnt, 1);
    chk_taps("run0", 0, 0, 1);
    chk("run0_line", int'(rdLine), 0);
    chk("run0_same", int'(sameLine), 0);

    // Full frame: write a line, advance the reader, rotate mod 4
    for (int i = 0; i < 159; i++) begin
      if (i < 158) pixels(240);
      nl();
      chk("frm_line", int'(rdLine), i + 1);
      chk_taps("frm", i % 4, (i + 1) % 4, (i == 158) ? (i + 1) % 4 : (i + 2) % 4);
    end
    chk("frm_ovf", int'(overflow), 0);
    chk("frm_und", int'(underrun), 0);
    chk("frm_same", int'(sameLine), 1);
    chk("frm_fs_cnt", fs_cnt, 1);

    // Reset asserted mid-stream, pixels ignored afterwards until a frame start
    gbaPxlValid = 1'b1;
    repeat (5) tick();
    rstN = 1'b0;
    repeat (3) tick();
    chk_reset_state("mid");
    rstN = 1'b1;
    base = wr_cnt;
    repeat (5) tick();
    gbaPxlValid = 1'b0;
    chk("mid_ignore", wr_cnt - base, 0);

    // Underrun: one line ready, two nextLine pulses
    start_frame();
    nl();
    chk("und1_line", int'(rdLine), 1);
    chk_taps("und1", 0, 1, 1);
    chk("und1_same", int'(sameLine), 1);
    chk("und1_flag", int'(underrun), 0);
    nl();
    chk("und2_line", int'(rdLine), 1);
    chk_taps("und2", 0, 1, 1);
    chk("und2_same", int'(sameLine), 1);
    chk("und2_flag", int'(underrun), 1);

    // Writer runs ahead until the next bank is the prev tap, then drops
    start_frame();
    pixels(480);
    tick();
    chk("blk_same", int'(sameLine), 0);
    chk("blk_ovf0", int'(overflow), 0);
    base = wr_cnt;
    pixels(10);
    tick();
    chk("blk_dropped", wr_cnt - base, 0);
    chk("blk_ovf1", int'(overflow), 1);
    nl();
    nl();
    chk("blk_line", int'(rdLine), 2);
    chk_taps("blk", 1, 2, 3);
    gbaPxlValid = 1'b1;
    tick();
    gbaPxlValid = 1'b0;
    chk("res_wren", int'(wrEn), 1);
    chk("res_addr", int'(wrAddr), 0);
    chk("res_bank", int'(wrBank), 0);
    do_reset();
    chk("rst_ovf_clr", int'(overflow), 0);

    // Resync: frame start while the reader sits at line 57
    start_frame();
    for (int i = 0; i < 57; i++) begin
      pixels(240);
      nl();
    end
    chk("rsy_line57", int'(rdLine), 57);
    pixels(100);
    base = fs_cnt;
    nf_pulse();
    chk("rsy_same", int'(sameLine), 1);
    chk("rsy_line_held", int'(rdLine), 57);
    chk("rsy_cur_held", int'(rdBankCur), 1);
    gbaPxlValid = 1'b1;
    tick();
    chk("rsy_addr0", int'(wrAddr), 0);
    chk("rsy_bank", int'(wrBank), 3);
    repeat (479) tick();
    gbaPxlValid = 1'b0;
    repeat (4) tick();
    chk("rsy_fs_cnt", fs_cnt - base, 1);
    chk("rsy_fs_line", fs_line, 0);
    chk("rsy_line0", int'(rdLine), 0);
    chk_taps("rsy", 3, 3, 0);
    chk("rsy_same_run", int'(sameLine), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
